// File: rtl/one_to_four_demux_tdm.sv
// TDM-to-4-lane demultiplexer: locks on frame_sync, assembles four lane samples
// and publishes them atomically on frame_out. Optional macro: DEMUX_STRICT_SYNC_EN.
module one_to_four_demux_tdm #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               frame_sync,
  output logic [4*WIDTH-1:0] frame_out,
  output logic               out_valid,
  output logic [3:0]         lane_strobe,
  output logic [1:0]         lane_idx,
  output logic               locked,
  output logic               sync_err
);

  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;

  state_t             state, state_n;
  logic [1:0]         cnt, cnt_n;
  logic [WIDTH-1:0]   hold   [3];
  logic [WIDTH-1:0]   hold_n [3];
  logic [4*WIDTH-1:0] frame_n;
  logic               out_valid_n;
  logic [3:0]         strobe_n;
  logic               sync_err_n;

  assign lane_idx = cnt;
  assign locked   = (state == RUN);

  // NOTE: every comb output gets its hold-current default first, so no path leaves a latch.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hold_n      = hold;
    frame_n     = frame_out;
    out_valid_n = 1'b0;
    strobe_n    = 4'b0000;
    sync_err_n  = 1'b0;

    if (din_valid) begin
      if (state == HUNT) begin
        if (frame_sync) begin
          hold_n[0] = din;
          cnt_n     = 2'd1;
          state_n   = RUN;
          strobe_n  = 4'b0001;
        end
      end else if (frame_sync && (cnt != 2'd0)) begin
        // Early sync: drop the partial frame and realign on this sample as lane 0.
        sync_err_n = 1'b1;
        hold_n[0]  = din;
        cnt_n      = 2'd1;
        strobe_n   = 4'b0001;
`ifdef DEMUX_STRICT_SYNC_EN
      end else if (!frame_sync && (cnt == 2'd0)) begin
        sync_err_n = 1'b1;
        state_n    = HUNT;
        cnt_n      = 2'd0;
`endif
      end else begin
        strobe_n = 4'b0001 << cnt;
        cnt_n    = cnt + 2'd1;
        case (cnt)
          2'd0: hold_n[0] = din;
          2'd1: hold_n[1] = din;
          2'd2: hold_n[2] = din;
          default: begin
            frame_n     = {din, hold[2], hold[1], hold[0]};
            out_valid_n = 1'b1;
          end
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= HUNT;
      cnt         <= 2'd0;
      // NOTE: the lane holding registers are reset too; they are a few flops, not a RAM.
      hold        <= '{default: '0};
      frame_out   <= '0;
      out_valid   <= 1'b0;
      lane_strobe <= 4'b0000;
      sync_err    <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      hold        <= hold_n;
      frame_out   <= frame_n;
      out_valid   <= out_valid_n;
      lane_strobe <= strobe_n;
      sync_err    <= sync_err_n;
    end
  end

endmodule

// File: tb/tb_one_to_four_demux_tdm.sv
// Randomized + directed bench for one_to_four_demux_tdm (WIDTH=8) against a
// frame-assembly reference model; honours DEMUX_STRICT_SYNC_EN like the design.
module tb_one_to_four_demux_tdm;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [W-1:0]   din;
  logic           din_valid;
  logic           frame_sync;
  logic [4*W-1:0] frame_out;
  logic           out_valid;
  logic [3:0]     lane_strobe;
  logic [1:0]     lane_idx;
  logic           locked;
  logic           sync_err;

  one_to_four_demux_tdm #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .frame_sync (frame_sync),
    .frame_out  (frame_out),
    .out_valid  (out_valid),
    .lane_strobe(lane_strobe),
    .lane_idx   (lane_idx),
    .locked     (locked),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a list of samples collected for the frame being assembled.
  logic [W-1:0]   part [4];
  int             part_n;
  bit             m_locked;
  logic [4*W-1:0] m_frame;
  bit             e_ov, e_err;
  logic [3:0]     e_strobe;

  int cyc;
  int ov_count;
  int ov_cyc [$];

  function automatic void model_reset();
    part_n   = 0;
    m_locked = 0;
    m_frame  = '0;
  endfunction

  function automatic void model_beat(input bit v, input bit s, input logic [W-1:0] d);
    bit strict;
`ifdef DEMUX_STRICT_SYNC_EN
    strict = 1;
`else
    strict = 0;
`endif
    e_ov = 0; e_err = 0; e_strobe = 4'b0000;
    if (!v) return;
    if (!m_locked) begin
      if (s) begin
        m_locked = 1; part[0] = d; part_n = 1; e_strobe = 4'b0001;
      end
    end else if (s && part_n != 0) begin
      e_err = 1; part[0] = d; part_n = 1; e_strobe = 4'b0001;
    end else if (!s && part_n == 0 && strict) begin
      e_err = 1; m_locked = 0;
    end else begin
      part[part_n] = d;
      e_strobe = 4'(1 << part_n);
      part_n++;
      if (part_n == 4) begin
        m_frame = {part[3], part[2], part[1], part[0]};
        e_ov    = 1;
        part_n  = 0;
      end
    end
  endfunction

  task automatic beat(input bit v, input bit s, input logic [W-1:0] d);
    din = d; din_valid = v; frame_sync = s;
    model_beat(v, s, d);
    @(posedge clk); #1;
    cyc++;
    check("frame_out", frame_out, m_frame);
    check("out_valid", 32'(out_valid), 32'(e_ov));
    check("lane_strobe", 32'(lane_strobe), 32'(e_strobe));
    check("lane_idx", 32'(lane_idx), m_locked ? 32'(part_n) : 32'd0);
    check("locked", 32'(locked), 32'(m_locked));
    check("sync_err", 32'(sync_err), 32'(e_err));
    if (out_valid) begin
      ov_count++;
      ov_cyc.push_back(cyc);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, $urandom_range(0, 1), W'($urandom));
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_frame"}, frame_out, 32'd0);
    check({tag, "_ov"}, 32'(out_valid), 32'd0);
    check({tag, "_strobe"}, 32'(lane_strobe), 32'd0);
    check({tag, "_idx"}, 32'(lane_idx), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_err"}, 32'(sync_err), 32'd0);
  endtask

  // Asserts rst 2 ns into a cycle and checks outputs before the next clock edge.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1 check_zero("rst_async");
    model_reset();
    din_valid = 1'b0; frame_sync = 1'b0; din = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; din_valid = 1'b0; frame_sync = 1'b0;
    cyc = 0; ov_count = 0;
    model_reset();
    #12 check_zero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Normal frame
    beat(1, 1, 8'hA0); beat(1, 0, 8'hA1); beat(1, 0, 8'hA2); beat(1, 0, 8'hA3);
    check("normal_frame", frame_out, 32'hA3A2A1A0);

    // Mid-frame reset
    beat(1, 1, 8'hB0); beat(1, 0, 8'hB1);
    do_reset();

    // Stalls, then two back-to-back frames
    for (int k = 0; k < 4; k++) begin
      beat(1, k == 0, 8'h50 + 8'(k));
      idle(3);
    end
    check("stall_frame", frame_out, 32'h53525150);
    ov_count = 0;
    ov_cyc.delete();
    for (int f = 0; f < 2; f++)
      for (int k = 0; k < 4; k++)
        beat(1, k == 0, 8'h10 * 8'(f + 1) + 8'(k));
    check("b2b_frame", frame_out, 32'h23222120);
    check("b2b_ov_count", 32'(ov_count), 32'd2);
    if (ov_cyc.size() == 2) check("b2b_ov_spacing", 32'(ov_cyc[1] - ov_cyc[0]), 32'd4);

    // HUNT filtering
    do_reset();
    for (int i = 0; i < 5; i++) beat(1, 0, W'($urandom));
    check("hunt_locked", 32'(locked), 32'd0);
    beat(1, 1, 8'h55);
    check("hunt_lock_rise", 32'(locked), 32'd1);

    // Early sync
    do_reset();
    ov_count = 0;
    beat(1, 1, 8'h01); beat(1, 0, 8'h02);
    beat(1, 1, 8'h03);
    check("early_err", 32'(sync_err), 32'd1);
    beat(1, 0, 8'h04); beat(1, 0, 8'h05); beat(1, 0, 8'h06);
    check("early_frame", frame_out, 32'h06050403);
    check("early_ov_count", 32'(ov_count), 32'd1);

    // Missing sync at frame boundary
    beat(1, 1, 8'h30); beat(1, 0, 8'h31); beat(1, 0, 8'h32); beat(1, 0, 8'h33);
    beat(1, 0, 8'h40);
`ifdef DEMUX_STRICT_SYNC_EN
    check("miss_err", 32'(sync_err), 32'd1);
    check("miss_locked", 32'(locked), 32'd0);
`else
    check("miss_err", 32'(sync_err), 32'd0);
    check("miss_idx", 32'(lane_idx), 32'd1);
`endif
    check("miss_frame", frame_out, 32'h33323130);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      else beat($urandom_range(0, 3) != 0,
                (part_n == 0) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 19) == 0),
                W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
